// File: rtl/store_narrow_pkg.sv
// Shared encodings for the narrow-store engine: store sizes, FSM states and
// the alignment rule used to reject a request before any memory access.
package store_narrow_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_e;

   // Reserved size, odd half address or non-word-aligned word is refused.
   function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         SZ_RSVD: bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_narrow_byte_merge.sv
// Little-endian lane replacement: overlays the low byte/half/word of the store
// data onto the old memory word at the lanes selected by the address offset.
module byte_merge
   import store_narrow_pkg::*;
(
   input  logic [31:0] old_i,
   input  logic [31:0] data_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      case (size_i)
         SZ_BYTE: merged_o[{off_i, 3'b000} +: 8] = data_i[7:0];
         SZ_HALF: begin
            if (off_i[1]) merged_o[31:16] = data_i[15:0];
            else          merged_o[15:0]  = data_i[15:0];
         end
         SZ_WORD: merged_o = data_i;
         default: merged_o = old_i;
      endcase
   end

endmodule

// File: rtl/store_narrow.sv
// Read-modify-write engine for byte/half/word stores to a word-wide memory.
// Define STORE_NARROW_WORD_BYPASS_EN to let aligned word stores skip the read.
module store_narrow
   import store_narrow_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [1:0]        size_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i
);

   state_e            r_state;
   state_e            w_next;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic [31:0]       r_rdata;
   logic [31:0]       w_merged;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_data  <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && req_i) begin
            r_size <= size_i;
            r_addr <= addr_i;
            r_data <= data_i;
         end
         if (r_state == ST_READ && mem_ack_i) r_rdata <= mem_rdata_i;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_i) begin
               if (is_bad_req(size_i, addr_i[1:0])) begin
                  w_next = ST_ERR;
               end else if (size_i == SZ_WORD) begin
`ifdef STORE_NARROW_WORD_BYPASS_EN
                  w_next = ST_WRITE;
`else
                  w_next = ST_READ;
`endif
               end else begin
                  w_next = ST_READ;
               end
            end
         end
         ST_READ:  if (mem_ack_i) w_next = ST_WRITE;
         ST_WRITE: if (mem_ack_i) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         ST_ERR:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // A bypassed word store merges over a stale r_rdata, but a word replaces every lane.
   byte_merge u_merge (
      .old_i    (r_rdata),
      .data_i   (r_data),
      .size_i   (r_size),
      .off_i    (r_addr[1:0]),
      .merged_o (w_merged)
   );

   assign busy_o      = (r_state != ST_IDLE);
   assign done_o      = (r_state == ST_DONE);
   assign err_o       = (r_state == ST_ERR);
   assign mem_rd_o    = (r_state == ST_READ);
   assign mem_wr_o    = (r_state == ST_WRITE);
   assign mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
   assign mem_wdata_o = (r_state == ST_WRITE) ? w_merged : 32'h0;

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: directed vector table, random stores against a
// lane-arithmetic memory model, and hand sequences for busy/reset corners.
module tb_store_narrow;

`ifdef STORE_NARROW_WORD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] data;
   logic        busy_o, done_o, err_o, mem_rd_o, mem_wr_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   store_narrow #(.ADDR_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .size_i      (size),
      .addr_i      (addr),
      .data_i      (data),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .mem_addr_o  (mem_addr_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (mem_ack)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   // Memory responder: acks a held strobe after ack_delay idle cycles.
   logic [31:0] mem [0:1023];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          rd_count = 0;
   int          wr_count = 0;
   int          both_high = 0;
   int          addr_bad = 0;
   int          done_pulses = 0;
   logic [31:0] last_wr_addr = 0;
   logic [31:0] last_wr_data = 0;

   always @(posedge clk) begin
      #2;
      if (mem_rd_o && mem_wr_o) both_high++;
      if (mem_rd_o || mem_wr_o) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            wait_cnt = 0;
            if (mem_rd_o) begin
               mem_rdata = mem[mem_addr_o[11:2]];
               rd_count++;
            end else begin
               mem[mem_addr_o[11:2]] = mem_wdata_o;
               last_wr_addr = mem_addr_o;
               last_wr_data = mem_wdata_o;
               wr_count++;
            end
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(negedge clk) if (done_o) done_pulses++;

   function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] model_word(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
      int sh;
      if (sz == 2'd0) begin
         sh = int'(a % 4) * 8;
         return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
         sh = ((a % 4) >= 2) ? 16 : 0;
         return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      return d;
   endfunction

   task automatic wait_idle();
      for (int k = 0; k < 40 && busy_o; k++) @(negedge clk);
   endtask

   task automatic run_vec(input string nm, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] init,
                          input logic [31:0] expw, input bit exp_err, input int dly);
      int   rd0, wr0, n, exp_lat;
      bit   strobe, got_done, got_err, after;
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      wait_idle();
      mem[a[11:2]] = init;
      ack_delay = dly;
      rd0 = rd_count;
      wr0 = wr_count;
      strobe = 0;
      @(negedge clk);
      size = sz; addr = a; data = d; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n = 1;
      while (!(done_o || err_o) && n < 60) begin
         if (mem_rd_o || mem_wr_o) strobe = 1;
         if ((mem_rd_o || mem_wr_o) && mem_addr_o !== wa) addr_bad++;
         @(negedge clk);
         n++;
      end
      got_done = done_o;
      got_err  = err_o;
      @(negedge clk);
      after = done_o | err_o;
      check({nm, " err"}, 32'(got_err), 32'(exp_err));
      check({nm, " done"}, 32'(got_done), 32'(!exp_err));
      check({nm, " pulse_width"}, 32'(after), 32'd0);
      if (exp_err) begin
         check({nm, " strobe"}, 32'(strobe), 32'd0);
         check({nm, " writes"}, 32'(wr_count - wr0), 32'd0);
      end else begin
         check({nm, " writes"}, 32'(wr_count - wr0), 32'd1);
         check({nm, " wr_addr"}, last_wr_addr, wa);
         check({nm, " wr_data"}, last_wr_data, expw);
         check({nm, " reads"}, 32'(rd_count - rd0), (sz == 2'd2 && BYPASS) ? 32'd0 : 32'd1);
         if (dly == 0) begin
            exp_lat = (sz == 2'd2 && BYPASS) ? 3 : 4;
            check({nm, " latency"}, 32'(n + 1), 32'(exp_lat));
         end
      end
   endtask

   typedef struct {
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] init;
      logic [31:0] expw;
      bit          err;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra, rd, rinit;
      int          n, pulses0, wr0;
      bit          seen, busy_any;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst = 1'b1; req = 1'b0; size = 2'd0; addr = 32'h0; data = 32'h0;
      mem_ack = 1'b0; mem_rdata = 32'h0;

      vecs[0] = '{2'd0, 32'h101, 32'h12345678, 32'hAABBCCDD, 32'hAABB78DD, 1'b0};
      vecs[1] = '{2'd1, 32'h102, 32'h0000BEEF, 32'hAABBCCDD, 32'hBEEFCCDD, 1'b0};
      vecs[2] = '{2'd2, 32'h203, 32'hDEADBEEF, 32'h0,        32'h0,        1'b1};
      vecs[3] = '{2'd3, 32'h200, 32'hDEADBEEF, 32'h0,        32'h0,        1'b1};
      vecs[4] = '{2'd2, 32'h200, 32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 1'b0};
      vecs[5] = '{2'd0, 32'h300, 32'hFFFFFF5A, 32'h00000000, 32'h0000005A, 1'b0};
      vecs[6] = '{2'd0, 32'h303, 32'h000000C3, 32'h01020304, 32'hC3020304, 1'b0};
      vecs[7] = '{2'd1, 32'h100, 32'h1234ABCD, 32'hAABBCCDD, 32'hAABBABCD, 1'b0};
      vecs[8] = '{2'd1, 32'h101, 32'h1234ABCD, 32'hAABBCCDD, 32'h0,        1'b1};
      vecs[9] = '{2'd2, 32'h202, 32'h1234ABCD, 32'hAABBCCDD, 32'h0,        1'b1};

      #1;
      check("reset ctrl", {27'd0, busy_o, done_o, err_o, mem_rd_o, mem_wr_o}, 32'd0);
      check("reset addr", mem_addr_o, 32'd0);
      check("reset wdata", mem_wdata_o, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].sz, vecs[i].a, vecs[i].d,
                 vecs[i].init, vecs[i].expw, vecs[i].err, 0);

      for (int i = 0; i < 40; i++) begin
         rsz   = 2'($urandom_range(0, 3));
         ra    = 32'($urandom_range(0, 1023)) * 4 + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'd0);
         rd    = $urandom;
         rinit = $urandom;
         run_vec($sformatf("rnd%0d", i), rsz, ra, rd, rinit,
                 model_word(rsz, ra, rd, rinit), model_bad(rsz, ra), int'($urandom_range(0, 2)));
      end

      // Request during busy is dropped, not queued.
      wait_idle();
      mem[32'h180 >> 2] = 32'h55555555;
      mem[32'h1C0 >> 2] = 32'h77777777;
      ack_delay = 2;
      wr0 = wr_count;
      @(negedge clk); size = 2'd0; addr = 32'h180; data = 32'h000000A1; req = 1'b1;
      @(negedge clk); req = 1'b0;
      @(negedge clk); size = 2'd0; addr = 32'h1C0; data = 32'h000000B2; req = 1'b1;
      @(negedge clk); req = 1'b0;
      n = 0;
      while (!done_o && n < 40) begin @(negedge clk); n++; end
      check("busy_ign done", 32'(done_o), 32'd1);
      busy_any = 0;
      repeat (4) begin @(negedge clk); busy_any |= busy_o; end
      check("busy_ign idle_after", 32'(busy_any), 32'd0);
      check("busy_ign writes", 32'(wr_count - wr0), 32'd1);
      check("busy_ign word", mem[32'h180 >> 2], 32'h555555A1);
      check("busy_ign untouched", mem[32'h1C0 >> 2], 32'h77777777);

      // Delayed read ack, reset pulsed during WRITE, then an immediate new store.
      mem[32'h104 >> 2] = 32'h11223344;
      ack_delay = 3;
      wr0 = wr_count;
      pulses0 = done_pulses;
      @(negedge clk); size = 2'd0; addr = 32'h105; data = 32'h00000099; req = 1'b1;
      @(negedge clk); req = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (mem_wr_o) seen = 1;
         else @(negedge clk);
      end
      check("rst reached_write", 32'(seen), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst ctrl", {27'd0, busy_o, done_o, err_o, mem_rd_o, mem_wr_o}, 32'd0);
      check("rst addr", mem_addr_o, 32'd0);
      check("rst wdata", mem_wdata_o, 32'd0);
      #1 rst = 1'b0;
      check("rst no_write", 32'(wr_count - wr0), 32'd0);
      check("rst mem_kept", mem[32'h104 >> 2], 32'h11223344);
      ack_delay = 0;
      size = 2'd0; addr = 32'h105; data = 32'h00000099; req = 1'b1;
      @(negedge clk); req = 1'b0;
      check("rst first_accept", 32'(mem_rd_o), 32'd1);
      n = 0;
      while (!done_o && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      check("rst done_pulses", 32'(done_pulses - pulses0), 32'd1);
      check("rst new_word", mem[32'h104 >> 2], 32'h11229944);

      check("never rd&wr", 32'(both_high), 32'd0);
      check("addr stable", 32'(addr_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
